// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined add/subtract unit: chunk sizing and the
// configuration check used at elaboration time.
package pipelined_adder_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

   function automatic bit stages_divide(input int width, input int stages);
      return (stages > 0) && (width > 0) && ((width % stages) == 0);
   endfunction

   function automatic int chunk_of(input int width, input int stages);
      return (stages > 0) ? (width / stages) : width;
   endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational ripple-carry slice; exposes the carry into its MSB so the
// last slice can feed the signed-overflow detector.
module adder_slice #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   always_comb begin
      logic c;
      c     = cin;
      sum   = '0;
      c_msb = cin;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == WIDTH - 1) c_msb = c;
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice resolved per stage, carry
// registered between stages, whole pipe advancing together under valid/ready.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = chunk_of(WIDTH, STAGES);

   if (!stages_divide(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: STAGES must divide WIDTH exactly");
   end

   logic              adv;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic              ovf_q;

   logic [STAGES-1:0] st_v;
   logic [STAGES-1:0] st_c;
   logic [WIDTH-1:0]  st_a   [STAGES];
   logic [WIDTH-1:0]  st_b   [STAGES];
   logic [WIDTH-1:0]  st_res [STAGES];
   logic [WIDTH-1:0]  nres   [STAGES];

   logic [CHUNK-1:0]  sl_sum [STAGES];
   logic [STAGES-1:0] sl_cout;
   logic [STAGES-1:0] sl_cmsb;

   assign adv       = !vld_q[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = res_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

   // Stage 0 takes operands from the ports (subtract folds into ~b + 1);
   // later stages take the operands and carry delayed by the previous stage.
   always_comb begin
      st_v[0]   = in_valid;
      st_c[0]   = sub ? 1'b1 : cin;
      st_a[0]   = a;
      st_b[0]   = sub ? ~b : b;
      st_res[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         st_v[k]   = vld_q[k-1];
         st_c[k]   = carry_q[k-1];
         st_a[k]   = opa_q[k-1];
         st_b[k]   = opb_q[k-1];
         st_res[k] = res_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         nres[k]                  = st_res[k];
         nres[k][k*CHUNK +: CHUNK] = sl_sum[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(.WIDTH(CHUNK)) u_slice (
         .a     (st_a[k][k*CHUNK +: CHUNK]),
         .b     (st_b[k][k*CHUNK +: CHUNK]),
         .cin   (st_c[k]),
         .sum   (sl_sum[k]),
         .cout  (sl_cout[k]),
         .c_msb (sl_cmsb[k])
      );
   end

   // Data registers only load behind a valid token, so the output holds its
   // last result while bubbles pass through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            res_q[k] <= '0;
            opa_q[k] <= '0;
            opb_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q <= st_v;
         for (int k = 0; k < STAGES; k++) begin
            if (st_v[k]) begin
               res_q[k]   <= nres[k];
               carry_q[k] <= sl_cout[k];
               opa_q[k]   <= st_a[k];
               opb_q[k]   <= st_b[k];
            end
         end
         if (st_v[STAGES-1]) ovf_q <= sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vector table, backpressure run against a
// reference model, and reset-mid-flight in three configurations.
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;
   logic [7:0]  a8;
   logic [7:0]  b8;

   logic        inReady1, outValid1, cout1, ovf1;
   logic [31:0] sum1;
   logic        inReady2, outValid2, cout2, ovf2;
   logic [31:0] sum2;
   logic        inReady3, outValid3, cout3, ovf3;
   logic [7:0]  sum3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] expSum;
      logic        expCout;
      logic        expOvf;
   } vector_t;

   vector_t vectors [11];

   always #5 clk = ~clk;

   assign a8 = a[7:0];
   assign b8 = b[7:0];

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dutMain (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid1),
      .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   pipelined_adder #(.WIDTH(32), .STAGES(1)) dutOneStage (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady2),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid2),
      .out_ready(out_ready), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   pipelined_adder #(.WIDTH(8), .STAGES(8)) dutBitStages (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady3),
      .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(outValid3),
      .out_ready(out_ready), .sum(sum3), .cout(cout3), .ovf(ovf3)
   );

   // Reference: {ovf, cout, sum[31:0]} using a sign-based overflow rule.
   function automatic logic [33:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic s);
      logic [31:0] be;
      logic [32:0] r;
      logic        o;
      be = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, be} + {32'd0, (s ? 1'b1 : ci)};
      o  = (x[31] == be[31]) && (r[31] != x[31]);
      return {o, r};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                input logic ci, input logic s);
      a        = x;
      b        = y;
      cin      = ci;
      sub      = s;
      in_valid = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] opA [10];
      logic [31:0] opB [10];
      logic        opC [10];
      logic        opS [10];
      logic [33:0] expQ [$];
      logic [33:0] e;
      int          lat, sent, got, cyc, seen1, seen2, seen3;
      logic        accept;

      vectors[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vectors[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vectors[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vectors[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vectors[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vectors[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
      vectors[6]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
      vectors[7]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
      vectors[8]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vectors[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vectors[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

      // Reset with random inputs applied
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a         = $urandom;
      b         = $urandom;
      cin       = 1'b1;
      sub       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", outValid1, 0);
      checkOutput("rst_sum", sum1, 0);
      checkOutput("rst_cout", cout1, 0);
      checkOutput("rst_ovf", ovf1, 0);
      checkOutput("rst_out_valid_s1", outValid2, 0);
      checkOutput("rst_out_valid_w8", outValid3, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b0;
      #1;
      checkOutput("rst_in_ready", inReady1, 1);
      @(posedge clk);
      #1;

      // Directed vectors, one at a time, with latency measured
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, vectors[i].sub);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat      = 1;
         while (!outValid1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         checkOutput($sformatf("vec%0d_latency", i), lat, 4);
         checkOutput($sformatf("vec%0d_sum", i), sum1, vectors[i].expSum);
         checkOutput($sformatf("vec%0d_cout", i), cout1, vectors[i].expCout);
         checkOutput($sformatf("vec%0d_ovf", i), ovf1, vectors[i].expOvf);
      end
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back ops with random out_ready
      for (int i = 0; i < 10; i++) begin
         opA[i] = $urandom;
         opB[i] = $urandom;
         opC[i] = 1'($urandom_range(0, 1));
         opS[i] = 1'($urandom_range(0, 1));
      end
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 10 && cyc < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         if (sent < 10) applyStimulus(opA[sent], opB[sent], opC[sent], opS[sent]);
         else in_valid = 1'b0;
         #1;
         checkOutput("bp_in_ready", inReady1, !(outValid1 && !out_ready));
         accept = in_valid && inReady1;
         if (outValid1 && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("bp_unexpected_output", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("bp%0d_sum", got), sum1, e[31:0]);
               checkOutput($sformatf("bp%0d_cout", got), cout1, e[32]);
               checkOutput($sformatf("bp%0d_ovf", got), ovf1, e[33]);
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (accept) begin
            expQ.push_back(refModel(opA[sent], opB[sent], opC[sent], opS[sent]));
            sent++;
         end
         cyc++;
      end
      checkOutput("bp_result_count", got, 10);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Reset mid-flight: three ops accepted, reset before any result
      for (int i = 0; i < 3; i++) begin
         applyStimulus($urandom, $urandom, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("mid%0d_no_valid", i), outValid1, 0);
         checkOutput($sformatf("mid%0d_no_valid_w8", i), outValid3, 0);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      seen1 = 0;
      seen2 = 0;
      seen3 = 0;
      for (int i = 0; i < 12; i++) begin
         if (outValid1) seen1++;
         if (outValid2) seen2++;
         if (outValid3) seen3++;
         @(posedge clk);
         #1;
      end
      checkOutput("post_rst_valid_main", seen1, 0);
      checkOutput("post_rst_valid_s1", seen2, 0);
      checkOutput("post_rst_valid_w8", seen3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
